// File: rtl/wlmr_iter_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : wlmr_iter_reducer
//  Description : Iterative word-level Montgomery reducer for primes of the
//                form q = qH*2^W_SIZE + 1. Reduces one double-width product
//                T < q^2 by reusing a single stage for STAGES cycles and
//                returns T*2^(-W_SIZE*STAGES) mod q with valid/ready
//                handshakes on both sides.
//  Options     : define WLMR_CORR_EN to add the final conditional
//                subtraction (result in [0,q)); without it the result is
//                lazy (in [0,2q)) and arrives one cycle earlier.
//  Revision    : 1.0 - initial release
// ============================================================================
module wlmr_iter_reducer #(
  parameter int DATA_W = 32,
  parameter int W_SIZE = 16,
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*DATA_W-1:0]      in_data,
  input  logic [DATA_W-W_SIZE-1:0] in_qh,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W:0]          out_data,
  output logic                     busy
);

  localparam int ACC_W = 2*DATA_W + 1;
  localparam int QH_W  = DATA_W - W_SIZE;
  localparam int CNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RED  = 2'd1,
    S_CORR = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [QH_W-1:0]   qh_q,    qh_d;

  logic [W_SIZE-1:0] t2l;
  logic [W_SIZE-1:0] t2;
  logic              carry;
  logic [DATA_W-1:0] prod;
  logic [ACC_W-1:0]  stage_acc;
  logic              last_stage;

  // One Montgomery stage: add q*T2 to clear the low word, then drop it.
  // The low word plus T2 is either 0 or exactly 2^W_SIZE, so the carry into
  // the shifted value is simply (T2L != 0).
  always_comb begin
    t2l       = acc_q[W_SIZE-1:0];
    t2        = (~t2l) + W_SIZE'(1);
    carry     = |t2l;
    prod      = DATA_W'(qh_q) * DATA_W'(t2);
    stage_acc = (acc_q >> W_SIZE) + ACC_W'(prod) + ACC_W'(carry);
    last_stage = (cnt_q == CNT_W'(STAGES - 1));
  end

`ifdef WLMR_CORR_EN
  logic [ACC_W-1:0] q_full;
  logic [ACC_W-1:0] corr_acc;

  // Final conditional subtraction brings the [0,2q) result into [0,q).
  always_comb begin
    q_full   = ACC_W'({qh_q, {W_SIZE{1'b0}}}) + ACC_W'(1);
    corr_acc = (acc_q >= q_full) ? (acc_q - q_full) : acc_q;
  end
`endif

  // Next-state and datapath update for the IDLE/RED/CORR/DONE sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    qh_d    = qh_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = ACC_W'(in_data);
          qh_d    = in_qh;
          cnt_d   = '0;
          state_d = S_RED;
        end
      end
      S_RED: begin
        acc_d = stage_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_stage) begin
`ifdef WLMR_CORR_EN
          state_d = S_CORR;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef WLMR_CORR_EN
      S_CORR: begin
        acc_d   = corr_acc;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operand.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      qh_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      qh_q    <= qh_d;
    end
  end

  // Handshake and status outputs decode the registered state only.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    out_data  = out_valid ? acc_q[DATA_W:0] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_wlmr_iter_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wlmr_iter_reducer
//  Description : Self-checking bench for wlmr_iter_reducer at DATA_W=5,
//                W_SIZE=4, STAGES=2, q=17 (qH=1). Honours WLMR_CORR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wlmr_iter_reducer;

  localparam int DATA_W = 5;
  localparam int W_SIZE = 4;
  localparam int STAGES = 2;
  localparam int Q      = 17;
  localparam int R      = 256;   // 2^(W_SIZE*STAGES)
  localparam int QINV   = 241;   // 17^-1 mod 256

  logic                     clk;
  logic                     n_reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [2*DATA_W-1:0]      in_data;
  logic [DATA_W-W_SIZE-1:0] in_qh;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W:0]          out_data;
  logic                     busy;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  typedef struct {
    int t;
    int exp_corr;
    int exp_lazy;
  } vec_t;

  vec_t vecs[9];

  wlmr_iter_reducer #(
    .DATA_W (DATA_W),
    .W_SIZE (W_SIZE),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_qh     (in_qh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog against any unbounded stall.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One-shot Montgomery reference: (T + q*m)/R with m = -T*q^-1 mod R.
  function automatic int model(input int t);
    int m, r;
    m = (((R - (t % R)) % R) * QINV) % R;
    r = (t + Q * m) / R;
`ifdef WLMR_CORR_EN
    if (r >= Q) r = r - Q;
`endif
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compare every accepted result with the oldest expectation.
  always @(negedge clk) begin
    if (n_reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d with no expected value queued", out_data);
      end else begin
        check("result", int'(out_data), exp_q.pop_front());
      end
    end
  end

  // Offer one operand and return just after the edge that accepts it.
  task automatic send(input int t, input bit push);
    bit fired;
    in_valid = 1'b1;
    in_data  = (2*DATA_W)'(t);
    in_qh    = 1'b1;
    if (push) exp_q.push_back(model(t));
    fired = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        fired = 1'b1;
        break;
      end
    end
    if (!fired) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending results got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int lat;
    bit seen;

    vecs[0] = '{256, 1, 1};
    vecs[1] = '{288, 16, 16};
    vecs[2] = '{272, 0, 17};
    vecs[3] = '{0, 0, 0};
    vecs[4] = '{1, 1, 1};
    vecs[5] = '{100, 15, 15};
    vecs[6] = '{17, 0, 17};
    vecs[7] = '{34, 0, 17};
    vecs[8] = '{200, 13, 13};

    n_reset   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_qh     = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_busy", int'(busy), 0);

    // Hand-computed table, both configurations.
    for (int i = 0; i < 9; i++) begin
      int e;
`ifdef WLMR_CORR_EN
      e = vecs[i].exp_corr;
`else
      e = vecs[i].exp_lazy;
`endif
      check("table_vs_model", model(vecs[i].t), e);
      @(posedge clk);
      #1;
      send(vecs[i].t, 1'b1);
      wait_done();
    end

    // Random operands T < q^2 against the reference model.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      send(int'($urandom_range(0, Q*Q - 1)), 1'b1);
      wait_done();
    end

    // Latency: edges from the accepting edge (inclusive) to out_valid.
    @(posedge clk);
    #1;
    send(256, 1'b1);
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
`ifdef WLMR_CORR_EN
    check("latency", seen ? lat : -1, STAGES + 2);
`else
    check("latency", seen ? lat : -1, STAGES + 1);
`endif
    wait_done();

    // Back-pressure: T=1 then T=0 offered back-to-back, output stalled.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(1, 1'b1);
    in_valid = 1'b1;
    in_data  = '0;
    in_qh    = 1'b1;
    exp_q.push_back(model(0));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_reach_done", int'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_data", int'(out_data), 1);
      check("stall_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);     // out_fire edge
    #1;
    check("post_fire_in_ready", int'(in_ready), 1);
    @(posedge clk);     // second operand accepted here
    #1;
    in_valid = 1'b0;
    check("second_busy", int'(busy), 1);
    wait_done();

    // Operand pulsed while busy must be ignored.
    @(posedge clk);
    #1;
    send(288, 1'b1);
    in_valid = 1'b1;
    in_data  = 10'd100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("ignored_no_extra_result", int'(seen), 0);
    check("ignored_busy", int'(busy), 0);

    // Reset during RED discards the operand.
    @(posedge clk);
    #1;
    send(15, 1'b0);
    #1;
    n_reset = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_out_data", int'(out_data), 0);
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", int'(in_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check("midreset_no_stale", int'(seen), 0);
    @(posedge clk);
    #1;
    send(256, 1'b1);
    wait_done();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
